alu_md: RTL and testbench
=========================

# alu_md

Parametrised execute-stage arithmetic unit: a combinational ALU for single-cycle operations plus an iterative multiply/divide engine with HI/LO result registers. It sits in the EX stage of the pipelined MIPS datapath. The ALU result feeds the EX/MEM register directly. The multiply/divide engine runs in the background under a start/busy handshake, and the hazard unit stalls on `busy`.

## Interface
- `WIDTH`, 32: data width; must be a power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived, do not override).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `A`  in  WIDTH  operand A (rs).
- `B`  in  WIDTH  operand B (rt/imm).
- `ALUOp`  in  4  combinational op select.
- `C`  out  WIDTH  combinational ALU result.
- `md_op`  in  3  mult/div/move op, sampled when `start`=1.
- `start`  in  1  issue strobe for `md_op`.
- `busy`  out  1  engine occupied; reset 0.
- `done`  out  1  one-cycle pulse when HI/LO receive a mult/div result; reset 0.
- `HI`  out  WIDTH  HI register; reset 0.
- `LO`  out  WIDTH  LO register; reset 0.

## Operation
ALUOp encoding (all others give C=0):
- 0 ADD, 1 SUB: modulo 2^WIDTH, no overflow flag.
- 2 AND, 3 OR, 4 XOR, 10 NOR.
- 5 SLL, 6 SRL (logical), 7 SRA: shift amount is `B[SHW-1:0]`; upper B bits are ignored.
- 8 SLTU, 9 SLT: C is 1 or 0, zero-extended.

md_op encoding:
- 0 NOP.
- 1 MULTU, 2 MULT: {HI,LO} = full 2·WIDTH product.
- 3 DIVU, 4 DIV: LO = quotient, HI = remainder.
- 5 MTHI: HI=A. 6 MTLO: LO=A.
- 7 reserved, treated as NOP.

Multiply/divide engine:
- States: IDLE, MUL, DIV, FIX.
- IDLE→MUL/DIV on `start` with md_op 1–4. Operands are latched as magnitudes; the result-sign flags are recorded at this point.
- MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles, then →FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then →FIX.
- FIX: applies sign correction, writes HI/LO, pulses `done`, then →IDLE.
- Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend (A). No trap.
- Signed overflow (MIN / −1): LO = MIN, HI = 0.
- MTHI/MTLO with `start` in IDLE: write at the next edge. No `busy`, no `done`.
- `start` while `busy`=1 is ignored entirely; HI/LO and the operation in flight are unaffected.
- HI/LO keep their old values until the FIX edge.

## Timing
- C: purely combinational, zero latency.
- Mult/div issued with `start` at edge 0:
  - `busy`=1 from after edge 0 until after edge WIDTH+1.
  - HI/LO update and `done`=1 in the cycle following edge WIDTH+1.
  - Total latency WIDTH+1 cycles (33 at WIDTH=32).
- `busy` falls in the same cycle `done` rises. A new `start` is accepted in that cycle.
- MTHI/MTLO: HI/LO visible one cycle after the `start` edge.
- Reset asserted mid-operation: immediately forces IDLE, `busy`=0, `done`=0, HI=LO=0. The operation in flight is lost.

## Configuration
- `ALU_MD_DIV_EN` defined: DIVU/DIV implemented as specified.
- Not defined:
  - The DIV state and the divider datapath are removed.
  - md_op 3/4 behave as NOP: no `busy`, no `done`, HI/LO unchanged.
  - Multiply and move operations are unchanged.

## Structure
- Shared package `alu_pkg`: ALUOp localparams (ALU_ADD … ALU_NOR), md_op localparams (MD_NOP … MD_MTLO), and the engine state enum.
- One sub-module, `md_engine`: holds the FSM, iterative datapath, HI/LO and `busy`/`done`.
- Top `alu_md` holds the combinational ALU and instantiates `md_engine`.

## Test plan
All scenarios at WIDTH=32 unless stated.
- ALU sweep:
  - A=0xFFFFFFF0, B=0x24 → SLL C=0xFFFFFF00 (shift amount 4).
  - SRL C=0x0FFFFFFF.
  - SRA C=0xFFFFFFFF.
  - SLT C=1.
  - SLTU C=0.
  - NOR with B=0 → C=0x0000000F.
- MULT A=0xFFFFFFFE (−2), B=3:
  - `busy` high 33 cycles.
  - `done` pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU of the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- Divide corner cases:
  - DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` MTLO while `busy`: ignored, LO takes only the mult result.
- Back-to-back `start` in the `done` cycle: accepted.
- Reset at cycle 10 of a MULT: `busy`=0, HI=LO=0 immediately; a fresh MULT afterwards is correct.
- Build without `ALU_MD_DIV_EN`: DIVU start → `busy` stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide engine.
// ALU_MD_DIV_EN adds the divide state to the engine state enum.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_MULT  = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_DIV   = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2
`ifdef ALU_MD_DIV_EN
        , ST_DIV = 2'd3
`endif
    } md_state_e;

endpackage

// File: rtl/md_engine.sv
// Iterative multiply/divide engine with HI/LO registers and start/busy handshake.
// Divider datapath and DIV state exist only when ALU_MD_DIV_EN is defined.
module md_engine
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned W2  = 2 * WIDTH;

    md_state_e        state, state_n;
    logic [W2-1:0]    acc, acc_n;
    logic [WIDTH-1:0] opnd, opnd_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic             neg_q, neg_q_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n;

    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_add, mul_sum;
    logic [W2-1:0]    prod;

    // Operand magnitudes; sign only matters for the signed ops.
    assign sgn     = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg   = sgn & a[WIDTH-1];
    assign b_neg   = sgn & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign mul_add = acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}};
    assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + mul_add;
    assign prod    = neg_q ? -acc : acc;

`ifdef ALU_MD_DIV_EN
    logic             neg_r, neg_r_n, div0, div0_n, is_div, is_div_n;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    // acc holds {remainder, dividend/quotient shift register}.
    assign rem_sh = acc[W2-1:WIDTH-1];
    assign diff   = {1'b0, rem_sh} - {2'b00, opnd};
    assign q_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix  = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        opnd_n  = opnd;
        cnt_n   = cnt;
        neg_q_n = neg_q;
        hi_n    = hi;
        lo_n    = lo;
`ifdef ALU_MD_DIV_EN
        neg_r_n  = neg_r;
        div0_n   = div0;
        is_div_n = is_div;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULTU, MD_MULT: begin
                            acc_n   = {{WIDTH{1'b0}}, b_mag};
                            opnd_n  = a_mag;
                            neg_q_n = a_neg ^ b_neg;
                            cnt_n   = '0;
`ifdef ALU_MD_DIV_EN
                            is_div_n = 1'b0;
`endif
                            state_n = ST_MUL;
                        end
`ifdef ALU_MD_DIV_EN
                        MD_DIVU, MD_DIV: begin
                            acc_n    = {{WIDTH{1'b0}}, a_mag};
                            opnd_n   = b_mag;
                            neg_q_n  = a_neg ^ b_neg;
                            neg_r_n  = a_neg;
                            div0_n   = (b == '0);
                            is_div_n = 1'b1;
                            cnt_n    = '0;
                            state_n  = ST_DIV;
                        end
`endif
                        MD_MTHI: hi_n = a;
                        MD_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_n = {mul_sum, acc[WIDTH-1:1]};
                cnt_n = cnt + SHW'(1);
                if (cnt == SHW'(WIDTH - 1)) state_n = ST_FIX;
            end
`ifdef ALU_MD_DIV_EN
            ST_DIV: begin
                if (diff[WIDTH+1]) acc_n = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                else               acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                cnt_n = cnt + SHW'(1);
                if (cnt == SHW'(WIDTH - 1)) state_n = ST_FIX;
            end
`endif
            ST_FIX: begin
                {hi_n, lo_n} = prod;
`ifdef ALU_MD_DIV_EN
                if (is_div) begin
                    lo_n = div0 ? {WIDTH{1'b1}} : q_fix;
                    hi_n = r_fix;
                end
`endif
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
        done_n = (state == ST_FIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ALU_MD_DIV_EN
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            opnd  <= opnd_n;
            cnt   <= cnt_n;
            neg_q <= neg_q_n;
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef ALU_MD_DIV_EN
            neg_r  <= neg_r_n;
            div0   <= div0_n;
            is_div <= is_div_n;
`endif
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage arithmetic: combinational ALU plus the background multiply/divide engine.
// Define ALU_MD_DIV_EN to include DIVU/DIV in the engine.
module alu_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    assign sh = B[SHW-1:0];

    // Single-cycle ALU; unused encodings produce zero.
    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLL:  C = A << sh;
            ALU_SRL:  C = A >> sh;
            ALU_SRA:  C = $unsigned($signed(A) >>> sh);
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  C = '0;
        endcase
    end

    md_engine #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .a     (A),
        .b     (B),
        .md_op (md_op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (HI),
        .lo    (LO)
    );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: ALU sweep plus scoreboarded multiply/divide traffic.
module tb_alu_md;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B, C, HI, LO;
    logic [3:0]   ALUOp;
    logic [2:0]   md_op;
    logic         start, busy, done;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [63:0]  exp_q[$];
    string        tag_q[$];
    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ALUOp(ALUOp), .C(C),
        .md_op(md_op), .start(start), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference {HI,LO} for a completed mult/div.
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            MD_MULTU: return {32'h0, a} * {32'h0, b};
            MD_MULT:  return sa * sb;
            MD_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default:  return {m_hi, m_lo};
        endcase
    endfunction

    task automatic alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
        ALUOp = op; A = a; B = b;
        #1;
        check(tag, 64'(C), 64'(exp));
    endtask

    // Called at a negedge; the following posedge samples the strobe.
    task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
        md_op = op; A = a; B = b; start = 1'b1;
        if (push) begin
            exp_q.push_back(md_model(op, a, b));
            tag_q.push_back(tag);
        end
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NOP;
    endtask

    task automatic wait_done(input int exp_busy);
        int          nb = 0;
        int          guard = 0;
        string       tag;
        logic [63:0] exp;
        while (!done && guard < 200) begin
            if (busy) nb++;
            @(negedge clk);
            guard++;
        end
        tag = (tag_q.size() > 0) ? tag_q.pop_front() : "none";
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busycyc"}, 64'(nb), 64'(exp_busy));
        check({tag, "_busyoff"}, 64'(busy), 64'd0);
        check(tag, {HI, LO}, exp);
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NOP; A = '0; B = '0; ALUOp = ALU_ADD;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;

        alu("add",  ALU_ADD,  32'hFFFF_FFF0, 32'h24, 32'h0000_0014);
        alu("sub",  ALU_SUB,  32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFCC);
        alu("and",  ALU_AND,  32'hFFFF_FFF0, 32'h24, 32'h0000_0020);
        alu("or",   ALU_OR,   32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFF4);
        alu("xor",  ALU_XOR,  32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFD4);
        alu("sll",  ALU_SLL,  32'hFFFF_FFF0, 32'h24, 32'hFFFF_FF00);
        alu("srl",  ALU_SRL,  32'hFFFF_FFF0, 32'h24, 32'h0FFF_FFFF);
        alu("sra",  ALU_SRA,  32'hFFFF_FFF0, 32'h24, 32'hFFFF_FFFF);
        alu("slt",  ALU_SLT,  32'hFFFF_FFF0, 32'h24, 32'h0000_0001);
        alu("sltu", ALU_SLTU, 32'hFFFF_FFF0, 32'h24, 32'h0000_0000);
        alu("nor",  ALU_NOR,  32'hFFFF_FFF0, 32'h0,  32'h0000_000F);
        alu("sra31", ALU_SRA, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        alu("badop", 4'd13,   32'h1234_5678, 32'h1, 32'h0);
        @(negedge clk);

        issue("mult", MD_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1);
        wait_done(33);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        issue("multu", MD_MULTU, 32'hFFFF_FFFE, 32'h3, 1'b1);
        wait_done(33);

        // Moves take effect after one edge with no handshake activity.
        issue("mthi", MD_MTHI, 32'hA5A5_0001, 32'h0, 1'b0);
        check("mthi_hi", 64'(HI), 64'hA5A5_0001);
        check("mthi_busy", 64'(busy), 64'd0);
        m_hi = 32'hA5A5_0001;
        issue("mtlo", MD_MTLO, 32'h5A5A_0002, 32'h0, 1'b0);
        check("mtlo_lo", 64'(LO), 64'h5A5A_0002);
        check("mtlo_done", 64'(done), 64'd0);
        m_lo = 32'h5A5A_0002;

        // MTLO while busy must be dropped.
        issue("mult_5x7", MD_MULT, 32'd5, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        md_op = MD_MTLO; A = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NOP;
        check("busy_mtlo_lo", 64'(LO), 64'(m_lo));
        wait_done(27);

        // Back-to-back: second strobe in the done cycle.
        issue("b2b_a", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_done(33);
        issue("b2b_b", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(33);

        for (int i = 0; i < 3; i++) begin
            issue("rnd_mult", MD_MULT, $urandom, $urandom, 1'b1);
            wait_done(33);
            issue("rnd_multu", MD_MULTU, $urandom, $urandom, 1'b1);
            wait_done(33);
        end

`ifdef ALU_MD_DIV_EN
        issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(33);
        issue("divu_by0", MD_DIVU, 32'd7, 32'd0, 1'b1);
        wait_done(33);
        issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(33);
        issue("div_by0_neg", MD_DIV, 32'hFFFF_FF00, 32'd0, 1'b1);
        wait_done(33);
        for (int i = 0; i < 3; i++) begin
            issue("rnd_div", MD_DIV, $urandom, $urandom_range(32'hFFFF_FFFF, 1), 1'b1);
            wait_done(33);
            issue("rnd_divu", MD_DIVU, $urandom, $urandom_range(32'hFFFF, 1), 1'b1);
            wait_done(33);
        end
`else
        issue("nodiv", MD_DIVU, 32'd7, 32'd0, 1'b0);
        check("nodiv_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("nodiv_done", 64'(done), 64'd0);
        check("nodiv_hilo", {HI, LO}, {m_hi, m_lo});
`endif

        // Reset during a multiply discards it and clears HI/LO at once.
        @(negedge clk);
        issue("lost", MD_MULT, 32'd123, 32'd456, 1'b1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hilo", {HI, LO}, 64'd0);
        exp_q.delete();
        tag_q.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue("post_rst", MD_MULT, 32'hFFFF_FFFB, 32'd7, 1'b1);
        wait_done(33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
